// File: rtl/gestor_perifericos_n.sv
// gestor_perifericos_n: addressed peripheral manager between the datapath and
// N_ENTRADAS synchronised input ports / N_SAIDAS registered output ports.
// Input changes raise sticky per-port flags that are ORed into an interrupt.
module gestor_perifericos_n #(
  parameter int LARGURA    = 8,
  parameter int N_ENTRADAS = 4,
  parameter int N_SAIDAS   = 4,
  parameter int ADDR_W     = 2
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           ESCR_P,
  input  logic                           LER_P,
  input  logic [ADDR_W-1:0]              Endereco,
  input  logic [LARGURA-1:0]             Operando1,
  input  logic [N_ENTRADAS*LARGURA-1:0]  PIN,
  output logic [LARGURA-1:0]             Dados_IN,
  output logic [N_SAIDAS*LARGURA-1:0]    POUT,
  output logic [N_ENTRADAS-1:0]          Alteracao,
  output logic                           INT
);

  logic [N_ENTRADAS*LARGURA-1:0] s1;
  logic [N_ENTRADAS*LARGURA-1:0] s2;
  logic [N_ENTRADAS*LARGURA-1:0] prev;
  logic [N_ENTRADAS-1:0]         mudou;
  logic [N_ENTRADAS-1:0]         clr;
  logic [LARGURA-1:0]            rd_data;

  // Per-port change detect: any bit difference between synchronised and previous value.
  for (genvar g = 0; g < N_ENTRADAS; g++) begin : g_mudou
    assign mudou[g] = (s2[g*LARGURA +: LARGURA] != prev[g*LARGURA +: LARGURA]);
  end

  // Read-port decode: selected synchronised data and the flag to clear.
  // Addresses with no matching port leave rd_data at 0 and clear nothing.
  always_comb begin
    // NOTE: defaults first so every path assigns both signals; no latch is inferred.
    rd_data = '0;
    clr     = '0;
    for (int i = 0; i < N_ENTRADAS; i++) begin
      if (Endereco == ADDR_W'(i)) begin
        rd_data = s2[i*LARGURA +: LARGURA];
        clr[i]  = LER_P;
      end
    end
  end

  // Synchroniser, previous-value tracking, sticky flags (set beats clear) and interrupt.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1        <= '0;
      s2        <= '0;
      prev      <= '0;
      Alteracao <= '0;
      INT       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples pre-edge values,
      // which is what makes s1 -> s2 -> prev a real pipeline.
      s1        <= PIN;
      s2        <= s1;
      prev      <= s2;
      Alteracao <= (Alteracao & ~clr) | mudou;
      INT       <= |Alteracao;
    end
  end

  // Read data register: loads on a read strobe, holds otherwise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      Dados_IN <= '0;
    end else if (LER_P) begin
      Dados_IN <= rd_data;
    end
  end

  // Output port registers: only the addressed slice loads; out-of-range writes are dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      POUT <= '0;
    end else if (ESCR_P) begin
      for (int i = 0; i < N_SAIDAS; i++) begin
        if (Endereco == ADDR_W'(i)) begin
          POUT[i*LARGURA +: LARGURA] <= Operando1;
        end
      end
    end
  end

endmodule

// File: doc/gestor_perifericos_n.md
# gestor_perifericos_n

Parametrised peripheral manager connecting the processor datapath to several input and output ports. It replaces the single-port manager with addressed access to `N_ENTRADAS` input ports and `N_SAIDAS` output ports of configurable width. Input ports are synchronised, and changes are latched into per-port sticky flags that drive a single interrupt request. The block sits between the execution unit (which supplies `Operando1` and the access strobes) and the external pins.

## Interface

Parameters:
- `LARGURA`, default 8: data width of every port and of the datapath bus.
- `N_ENTRADAS`, default 4: number of input ports, 1..2^`ADDR_W`.
- `N_SAIDAS`, default 4: number of output ports, 1..2^`ADDR_W`.
- `ADDR_W`, default 2: width of the port address.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ESCR_P`  in  1  write strobe: writes `Operando1` to output port `Endereco`.
- `LER_P`  in  1  read strobe: reads input port `Endereco` and clears its change flag.
- `Endereco`  in  `ADDR_W`  port address shared by reads and writes.
- `Operando1`  in  `LARGURA`  write data from the datapath.
- `PIN`  in  `N_ENTRADAS*LARGURA`  asynchronous input pins; port i occupies bits [i*LARGURA +: LARGURA].
- `Dados_IN`  out  `LARGURA`  registered read data to the datapath.
- `POUT`  out  `N_SAIDAS*LARGURA`  registered output ports, using the same slicing as `PIN`.
- `Alteracao`  out  `N_ENTRADAS`  sticky per-port change flags.
- `INT`  out  1  registered interrupt request: OR of all `Alteracao` bits.

## Operation

- **Reset:** `reset_n` low asynchronously clears all registers to 0: synchroniser stages, previous-value registers, `Dados_IN`, `POUT`, `Alteracao` and `INT`. A reset asserted mid-operation aborts any in-flight change detection; no flag is set for a value captured before reset.
- **Input synchronisation:** each `PIN` bit passes through 2 flip-flops, `s1` then `s2`. `S[i]` is the `s2` slice of port i.
- **Change detection:**
  - Register `prev[i]` loads `S[i]` every cycle.
  - `mudou[i] = (S[i] != prev[i])`; any bit difference counts as a change.
  - On an edge where `mudou[i]` is 1, `Alteracao[i]` is set.
- **Read** (`LER_P` = 1):
  - If `Endereco < N_ENTRADAS`, `Dados_IN` loads `S[Endereco]` as it stands before the edge.
  - If `Endereco >= N_ENTRADAS`, `Dados_IN` loads 0.
  - With `LER_P` = 0, `Dados_IN` holds its value.
- **Flag clear:** a read of an in-range port i clears `Alteracao[i]` on the same edge. If `mudou[i]` and the clear occur in the same cycle, the set wins and the flag stays 1, so no change is lost.
- **Write** (`ESCR_P` = 1):
  - If `Endereco < N_SAIDAS`, the `POUT` slice `Endereco` loads `Operando1`; other slices hold.
  - If `Endereco >= N_SAIDAS`, the write is ignored.
- **Simultaneous `ESCR_P` and `LER_P`:** both operations are performed at the same address. Input and output spaces are independent.
- **`INT`:** `INT` = registered `|Alteracao`. It deasserts one cycle after the last flag clears.
- **Width rules:**
  - No arithmetic is performed.
  - Addresses are compared unsigned.
  - Address values at or above a port count are legal and fall back to the out-of-range behaviour above.

## Timing

- **`PIN` change to flag:** `PIN` changes before edge k.
  - `s1` captures it at edge k and `s2` (`S`) at edge k+1.
  - `mudou` is 1 during cycle k+1..k+2.
  - `Alteracao` sets at edge k+2.
  - `INT` asserts at edge k+3.
  - `prev` catches up at edge k+2, so a single change produces one `mudou` pulse.
- **Read latency:** `LER_P` sampled at edge k puts data on `Dados_IN` after edge k. The flag clear is visible after edge k; `INT` drops after edge k+1 if no other flag is set.
- **Write latency:** `ESCR_P` sampled at edge k updates `POUT` after edge k.
- **Back-to-back:** strobes may be asserted every cycle; there is no busy state and no handshake beyond the single-cycle strobes.
- **Glitches:** a pin pulse shorter than one clock may be missed; this is accepted behaviour.

## Test plan

- **Reset:** drive `reset_n` = 0 with all `PIN` = FF, then release. Required: `Dados_IN`, `POUT`, `Alteracao` and `INT` all 0. The first `Alteracao` set occurs 2 edges after release for every port.
- **Write/read:** write 8'hA5 to port 2, then 8'h3C to port 0. Required: `POUT` slice 2 = A5 and slice 0 = 3C, other slices 0. A write to address 3 with `N_SAIDAS` = 3 leaves `POUT` unchanged.
- **Change latency:** set `PIN` port 1 to 8'h42 before edge k. Required: `Alteracao[1]` = 1 after edge k+2 and `INT` = 1 after edge k+3. A subsequent read of port 1 returns 42 and clears the flag; `INT` = 0 one edge later.
- **Set/clear collision:** read port 1 in the same cycle that `mudou[1]` = 1. Required: `Alteracao[1]` stays 1 and `Dados_IN` holds the pre-edge `S[1]`.
- **Out-of-range read:** with `N_ENTRADAS` = 3, read address 3. Required: `Dados_IN` = 0 and all flags unchanged.
- **Reset mid-operation:** assert `reset_n` = 0 asynchronously between edges while `INT` = 1 and `POUT` ≠ 0. Required: all outputs 0 immediately, without waiting for a clock edge.
